// File: rtl/icache_nway.sv
// Set-associative instruction cache with round-robin replacement, refill critical-word
// bypass and full-sweep flush. Tag/data arrays are synchronous-read RAMs, one pair per way.
module icache_nway #(
  parameter int WAYS       = 4,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              cpu_addr,
  input  logic                     cpu_req,
  input  logic                     cpu_flush,
  output logic                     cpu_miss,
  output logic [31:0]              cpu_rdata,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic [32*LINE_WORDS-1:0] mem_line
);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WRD_W  = OFF_W - 2;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_FILL = 2'd3;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [WRD_W-1:0] off;
  assign idx = cpu_addr[OFF_W+IDX_W-1:OFF_W];
  assign tag = cpu_addr[31:OFF_W+IDX_W];
  assign off = cpu_addr[OFF_W-1:2];

  logic unused_bits;
  assign unused_bits = ^cpu_addr[1:0];

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;
  logic [IDX_W-1:0]  idx_q;
  logic              flush_q, flush_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [31:0]       byp_q, byp_d;
  logic [RR_W-1:0]   rr_q [SETS];
  logic [RR_W-1:0]   rr_d [SETS];

  logic [RR_W-1:0]             victim, hit_way;
  logic [WAYS-1:0]             hit_w;
  logic [WAYS-1:0][LINE_W-1:0] dat_rd;
  logic                        hit, stable;
  logic [31:0]                 hit_word;
  logic [IDX_W-1:0]            wr_idx;
  logic [TAG_W:0]              tag_wd;

  assign victim = (WAYS > 1) ? rr_q[fill_idx_q] : '0;
  assign wr_idx = (state_q == S_INIT) ? sweep_q : fill_idx_q;
  assign tag_wd = (state_q == S_INIT) ? '0 : {1'b1, fill_tag_q};

  // Write-first read port: a fill landing on the set being read is visible next cycle,
  // so the post-fill IDLE cycle hits instead of re-requesting the line.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W:0]  tag_mem [SETS];
    logic [LINE_W-1:0] dat_mem [SETS];
    logic [TAG_W:0]  tag_rd_r;
    logic [LINE_W-1:0] dat_rd_r;
    logic            tag_we, dat_we;

    assign dat_we = !rst && (state_q == S_FILL) && (victim == RR_W'(w));
    assign tag_we = (!rst && (state_q == S_INIT)) || dat_we;

    always_ff @(posedge clk) begin
      if (tag_we) tag_mem[wr_idx] <= tag_wd;
      if (dat_we) dat_mem[wr_idx] <= line_q;
      tag_rd_r <= (tag_we && wr_idx == idx) ? tag_wd : tag_mem[idx];
      dat_rd_r <= (dat_we && wr_idx == idx) ? line_q : dat_mem[idx];
    end

    assign dat_rd[w] = dat_rd_r;
    assign hit_w[w]  = tag_rd_r[TAG_W] && (tag_rd_r[TAG_W-1:0] == tag);
  end

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) if (hit_w[w]) hit_way = RR_W'(w);
  end

  assign hit      = |hit_w;
  assign stable   = (idx == idx_q) && (state_q == S_IDLE);
  assign hit_word = dat_rd[hit_way][{off, 5'b0} +: 32];
  assign mem_addr = {cpu_addr[31:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    cpu_miss  = 1'b1;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_miss = cpu_req && !(stable && hit);
        if (stable && hit) cpu_rdata = hit_word;
        mem_req  = cpu_req && stable && !hit && !cpu_flush;
      end
      S_REQ: begin
        cpu_miss = cpu_req;
        mem_req  = 1'b1;
      end
      S_FILL: begin
        cpu_miss  = 1'b0;
        cpu_rdata = byp_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    flush_d    = flush_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    line_d     = line_q;
    byp_d      = byp_q;
    rr_d       = rr_q;
    case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cpu_flush) begin
          state_d = S_INIT;
          sweep_d = '0;
        end else if (cpu_req && stable && !hit) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        flush_d = flush_q || cpu_flush;
        if (mem_gnt) begin
          state_d    = S_FILL;
          line_d     = mem_line;
          byp_d      = mem_line[{off, 5'b0} +: 32];
          fill_idx_d = idx;
          fill_tag_d = tag;
        end
      end
      default: begin
        if (WAYS > 1) rr_d[fill_idx_q] = rr_q[fill_idx_q] + 1'b1;
        flush_d = 1'b0;
        if (flush_q || cpu_flush) begin
          state_d = S_INIT;
          sweep_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      idx_q   <= '0;
      flush_q <= 1'b0;
      rr_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      idx_q   <= idx;
      flush_q <= flush_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    fill_idx_q <= fill_idx_d;
    fill_tag_q <= fill_tag_d;
    line_q     <= line_d;
    byp_q      <= byp_d;
  end
endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: two geometries run back to back against a set/way/round-robin
// model; line data is a pure function of the address so any wrong-way read shows up.
module tb_icache_nway;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, sel = 1'b0;
  logic         cpu_req = 1'b0, cpu_flush = 1'b0, mem_gnt = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [511:0] mem_line = '0;
  logic         miss_a, miss_b, req_a, req_b;
  logic [31:0]  rdata_a, rdata_b, maddr_a, maddr_b;
  logic         rst_a, rst_b, miss, req;
  logic [31:0]  rdata, maddr;

  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;
  assign miss  = sel ? miss_b  : miss_a;
  assign req   = sel ? req_b   : req_a;
  assign rdata = sel ? rdata_b : rdata_a;
  assign maddr = sel ? maddr_b : maddr_a;

  icache_nway #(.WAYS(4), .SETS(128), .LINE_WORDS(16)) u_a (
    .clk(clk), .rst(rst_a), .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_flush(cpu_flush),
    .cpu_miss(miss_a), .cpu_rdata(rdata_a), .mem_req(req_a), .mem_addr(maddr_a),
    .mem_gnt(mem_gnt), .mem_line(mem_line));

  icache_nway #(.WAYS(2), .SETS(64), .LINE_WORDS(8)) u_b (
    .clk(clk), .rst(rst_b), .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_flush(cpu_flush),
    .cpu_miss(miss_b), .cpu_rdata(rdata_b), .mem_req(req_b), .mem_addr(maddr_b),
    .mem_gnt(mem_gnt), .mem_line(mem_line[255:0]));

  int n_vec = 0, n_err = 0;
  int ways, sets, lw, offw, idxw, last_idx;
  logic [31:0] mtag [128][4];
  bit          mval [128][4];
  int          mrr  [128];

  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tg, got, exp);
    end
  endtask

  function automatic logic [31:0] fmask();
    return (32'd1 << offw) - 32'd1;
  endfunction
  function automatic int fidx(input logic [31:0] a);
    return int'((a >> offw) & 32'(sets - 1));
  endfunction
  function automatic logic [31:0] ftag(input logic [31:0] a);
    return a >> (offw + idxw);
  endfunction
  function automatic logic [31:0] fline(input logic [31:0] a);
    return a & ~fmask();
  endfunction
  function automatic logic [31:0] fdata(input logic [31:0] a);
    return 32'hA000_0000 + ((a & fmask()) >> 2) + (fline(a) ^ 32'h1FC0_0040);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    for (int w = 0; w < ways; w++)
      if (mval[fidx(a)][w] && mtag[fidx(a)][w] == ftag(a)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_fill(input logic [31:0] a);
    int s;
    s = fidx(a);
    mtag[s][mrr[s]] = ftag(a);
    mval[s][mrr[s]] = 1'b1;
    mrr[s] = (mrr[s] + 1) % ways;
  endtask
  task automatic model_flush();
    for (int s = 0; s < 128; s++) for (int w = 0; w < 4; w++) mval[s][w] = 1'b0;
  endtask
  task automatic model_reset();
    model_flush();
    for (int s = 0; s < 128; s++) mrr[s] = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic samp();
    @(negedge clk);
  endtask

  task automatic load_line(input logic [31:0] a);
    mem_line = '0;
    for (int k = 0; k < lw; k++) mem_line[k*32 +: 32] = fdata(fline(a) + 32'(k * 4));
  endtask
  task automatic junk_line();
    for (int k = 0; k < 16; k++) mem_line[k*32 +: 32] = $urandom();
  endtask

  task automatic expect_init();
    for (int i = 0; i < sets; i++) begin
      samp();
      chk("init_miss", {31'b0, miss}, 32'd1);
      chk("init_req", {31'b0, req}, 32'd0);
      chk("init_rdata", rdata, 32'd0);
      step();
    end
    last_idx = fidx(cpu_addr);
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b1; cpu_addr = '0; cpu_flush = 1'b0; mem_gnt = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    expect_init();
  endtask

  task automatic fetch(input logic [31:0] a, input bit flush_in_req);
    int s, d;
    bit hit;
    s   = fidx(a);
    hit = model_hit(a);
    cpu_addr = a; cpu_req = 1'b1;
    if (s != last_idx) begin
      samp();
      chk("stale_miss", {31'b0, miss}, 32'd1);
      chk("stale_req", {31'b0, req}, 32'd0);
      chk("stale_rdata", rdata, 32'd0);
      step();
    end
    last_idx = s;
    samp();
    if (hit) begin
      chk("hit_miss", {31'b0, miss}, 32'd0);
      chk("hit_data", rdata, fdata(a));
      step();
    end else begin
      chk("miss_flag", {31'b0, miss}, 32'd1);
      chk("mem_req", {31'b0, req}, 32'd1);
      chk("mem_addr", maddr, fline(a));
      step();
      d = $urandom_range(0, 2);
      for (int i = 0; i < d; i++) begin
        samp();
        chk("req_hold", {31'b0, req}, 32'd1);
        chk("req_miss", {31'b0, miss}, 32'd1);
        step();
      end
      mem_gnt = 1'b1; load_line(a);
      if (flush_in_req) cpu_flush = 1'b1;
      samp();
      chk("gnt_req", {31'b0, req}, 32'd1);
      chk("gnt_rdata", rdata, 32'd0);
      step();
      mem_gnt = 1'b0; cpu_flush = 1'b0; junk_line();
      samp();
      chk("fill_miss", {31'b0, miss}, 32'd0);
      chk("fill_data", rdata, fdata(a));
      step();
      model_fill(a);
      if (flush_in_req) begin
        model_flush();
        expect_init();
      end
    end
  endtask

  task automatic idle(input int n, input bit stray);
    cpu_req = 1'b0; cpu_addr = $urandom();
    for (int i = 0; i < n; i++) begin
      mem_gnt = stray && ($urandom_range(0, 1) == 1);
      junk_line();
      samp();
      chk("idle_miss", {31'b0, miss}, 32'd0);
      chk("idle_req", {31'b0, req}, 32'd0);
      step();
    end
    mem_gnt = 1'b0;
    last_idx = fidx(cpu_addr);
  endtask

  // Flush with the request still up on the current set: no refill may start.
  task automatic flush_pulse(input bit with_req);
    cpu_req = with_req; cpu_flush = 1'b1;
    samp();
    chk("flush_req", {31'b0, req}, 32'd0);
    step();
    cpu_flush = 1'b0;
    model_flush();
    expect_init();
  endtask

  task automatic rst_in_req(input logic [31:0] a);
    cpu_addr = a; cpu_req = 1'b1;
    if (fidx(a) != last_idx) step();
    samp();
    chk("rr_req_start", {31'b0, req}, 32'd1);
    step();
    rst = 1'b1; mem_gnt = 1'b1; load_line(a);
    step();
    rst = 1'b0; mem_gnt = 1'b0;
    model_reset();
    expect_init();
  endtask

  function automatic logic [31:0] mk(input int tg, input int ix, input int wd);
    return (32'(tg) << (offw + idxw)) | (32'(ix) << offw) | (32'(wd) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic run_cfg(input bit s, input int w, input int st, input int l, input int nr);
    int pool [3];
    sel = s; ways = w; sets = st; lw = l;
    offw = $clog2(l) + 2; idxw = $clog2(st);
    pool = '{1, 5, st - 1};
    do_reset();
    fetch(32'h0000_0000, 1'b0);
    fetch(32'h1FC0_0040, 1'b0);
    fetch(32'h1FC0_0044, 1'b0);
    for (int t = 0; t <= ways; t++) fetch(mk(t, 3, 0), 1'b0);
    for (int t = 1; t <= ways; t++) fetch(mk(t, 3, t % lw), 1'b0);
    fetch(mk(0, 3, 1), 1'b0);
    flush_pulse(1'b0);
    fetch(32'h1FC0_0044, 1'b0);
    fetch(32'h1FC0_0048, 1'b0);
    flush_pulse(1'b1);
    fetch(mk(2, 7, 1), 1'b1);
    fetch(mk(2, 7, 2), 1'b0);
    rst_in_req(mk(3, 9, 0));
    fetch(mk(3, 9, 0), 1'b0);
    for (int i = 0; i < nr; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 13) fetch(mk($urandom_range(0, ways + 1), pool[$urandom_range(0, 2)],
                           $urandom_range(0, lw - 1)), 1'b0);
      else if (r < 18) idle($urandom_range(1, 3), 1'b1);
      else if (r == 18) fetch(mk($urandom_range(0, ways + 1), pool[$urandom_range(0, 2)], 0), 1'b1);
      else flush_pulse($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    run_cfg(1'b0, 4, 128, 16, 300);
    run_cfg(1'b1, 2, 64, 8, 300);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
